// File: rtl/bin2bcd_param_if.sv
// Handshake/bus bundle for bin2bcd_param: start request and operand in,
// BCD result with sign/overflow flags and busy/rdy status out.
interface bin2bcd_if #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
);
    logic                  en;
    logic [BIN_W-1:0]      bin_d_in;
    logic [4*DIGITS-1:0]   bcd_d_out;
    logic                  neg;
    logic                  ovf;
    logic                  busy;
    logic                  rdy;

    modport master (
        output en, bin_d_in,
        input  bcd_d_out, neg, ovf, busy, rdy
    );

    modport slave (
        input  en, bin_d_in,
        output bcd_d_out, neg, ovf, busy, rdy
    );
endinterface

// File: rtl/bin2bcd_param.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Build option: define BIN2BCD_SAT_EN to force all-9s on the output when ovf is set.
module bin2bcd_param #(
    parameter int BIN_W     = 12,
    parameter int DIGITS    = 4,
    parameter int SIGNED_IN = 0
) (
    input  logic       clk,
    input  logic       rst,
    bin2bcd_if.slave   bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sign_q, sign_d;
    logic               sticky_q, sticky_d;
    logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               rdy_q, rdy_d;

    logic               in_neg;
    logic [BIN_W-1:0]   in_mag;
    logic [BCD_W-1:0]   adj;

    // Negation held in BIN_W unsigned bits keeps -2^(BIN_W-1) exact.
    always_comb begin
        in_neg = (SIGNED_IN != 0) && bus.bin_d_in[BIN_W-1];
        in_mag = in_neg ? ({BIN_W{1'b0}} - bus.bin_d_in) : bus.bin_d_in;
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        always_comb begin
            adj[g*4 +: 4] = (work_q[g*4 +: 4] > 4'd4) ? (work_q[g*4 +: 4] + 4'd3)
                                                      : work_q[g*4 +: 4];
        end
    end

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        sticky_d  = sticky_q;
        bcd_out_d = bcd_out_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    state_d  = CONV;
                    bin_d    = in_mag;
                    sign_d   = in_neg;
                    work_d   = '0;
                    cnt_d    = '0;
                    sticky_d = 1'b0;
                end
            end
            CONV: begin
                // Bit leaving the top digit means the value reached 10^DIGITS.
                work_d   = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
                bin_d    = {bin_q[BIN_W-2:0], 1'b0};
                sticky_d = sticky_q | adj[BCD_W-1];
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
`ifdef BIN2BCD_SAT_EN
                bcd_out_d = sticky_q ? {DIGITS{4'h9}} : work_q;
`else
                bcd_out_d = work_q;
`endif
                neg_d   = sign_q;
                ovf_d   = sticky_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        rdy_d  = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            work_q    <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            sticky_q  <= 1'b0;
            bcd_out_q <= '0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            sticky_q  <= sticky_d;
            bcd_out_q <= bcd_out_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            rdy_q     <= rdy_d;
        end
    end

    assign bus.bcd_d_out = bcd_out_q;
    assign bus.neg       = neg_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = busy_q;
    assign bus.rdy       = rdy_q;
endmodule
